// File: rtl/reg_mem2sram_pkg.sv
// Shared types for the memory-request to SRAM stage: FSM states and the
// decoded operation of a captured request.
package reg_mem_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_ERR
  } op_e;

  // Exactly one enable set is a legal request; both or neither is malformed.
  function automatic op_e decode_op(input logic wr_en, input logic rd_en);
    case ({wr_en, rd_en})
      2'b10:   return OP_WR;
      2'b01:   return OP_RD;
      default: return OP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/reg_mem2sram_if.sv
// Level-held memory request bus between the bridge and the SRAM stage.
interface reg_mem2sram_if #(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 5
);
  logic                      mem_req_vld;
  logic                      mem_ack_vld;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_wr_en;
  logic                      mem_rd_en;
  logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
  logic [MEM_DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_req_vld, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    input  mem_ack_vld, mem_rd_data
  );

  modport slave (
    input  mem_req_vld, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    output mem_ack_vld, mem_rd_data
  );
endinterface

// File: rtl/reg_mem2sram.sv
// Drives a single-port synchronous SRAM from a level-held memory request and
// returns a one-cycle ack with registered read data. All outputs registered:
// the next-state logic computes next output values, one flop stage holds them.
module reg_mem2sram
  import reg_mem_sram_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_rst,
  reg_mem2sram_if.slave             mem,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] sram_rdata,
  output logic                      err_pulse
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  state_e                    state_q, state_nxt;
  op_e                       op_q, op_nxt;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [MEM_DATA_WIDTH-1:0] rd_data_q, rd_data_nxt;
  logic [CNT_W-1:0]          cnt_q, cnt_nxt;
  logic                      ack_q, ce_q, we_q, err_q;
  logic                      err_nxt;

  wire do_rst = !rst_n || soft_rst;

  // Next state, capture registers, latency counter and read-data return.
  always_comb begin
    state_nxt   = state_q;
    op_nxt      = op_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rd_data_nxt = rd_data_q;
    cnt_nxt     = cnt_q;
    err_nxt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.mem_req_vld) begin
          addr_nxt  = mem.mem_addr;
          wdata_nxt = mem.mem_wr_data;
          op_nxt    = decode_op(mem.mem_wr_en, mem.mem_rd_en);
          if (op_nxt == OP_ERR) begin
            // Malformed request: ack straight away, never touch the SRAM.
            state_nxt   = ACK;
            rd_data_nxt = '0;
            err_nxt     = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_WR) begin
          state_nxt = ACK;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rd_data_nxt = sram_rdata;
          state_nxt   = ACK;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      ACK:     state_nxt = HOLD;
      // Absorbs the cycle where upstream has not yet dropped its request.
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, capture and output registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (do_rst) begin
      state_q   <= IDLE;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rd_data_q <= rd_data_nxt;
      cnt_q     <= cnt_nxt;
      ack_q     <= (state_nxt == ACK);
      ce_q      <= (state_nxt == ISSUE);
      we_q      <= (state_nxt == ISSUE) && (op_nxt == OP_WR);
      err_q     <= err_nxt;
    end
  end

  assign mem.mem_ack_vld = ack_q;
  assign mem.mem_rd_data = rd_data_q;
  assign sram_ce         = ce_q;
  assign sram_we         = we_q;
  assign sram_addr       = addr_q;
  assign sram_wdata      = wdata_q;
  assign err_pulse       = err_q;

endmodule

// File: tb/tb_reg_mem2sram.sv
// Directed bench: two instances (read latency 1 and 4) share one stimulus
// stream, each backed by its own behavioural SRAM.
module tb_reg_mem2sram;

  logic        clk = 1'b0;
  logic        rst_n, soft_rst;
  logic        req, wr_en, rd_en;
  logic [4:0]  addr;
  logic [63:0] wdata;

  int total = 0;
  int bad   = 0;

  reg_mem2sram_if #(.MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(5)) b1();
  reg_mem2sram_if #(.MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(5)) b4();

  assign b1.mem_req_vld = req;   assign b4.mem_req_vld = req;
  assign b1.mem_wr_en   = wr_en; assign b4.mem_wr_en   = wr_en;
  assign b1.mem_rd_en   = rd_en; assign b4.mem_rd_en   = rd_en;
  assign b1.mem_addr    = addr;  assign b4.mem_addr    = addr;
  assign b1.mem_wr_data = wdata; assign b4.mem_wr_data = wdata;

  logic        ce1, we1, err1, ce4, we4, err4;
  logic [4:0]  ad1, ad4;
  logic [63:0] wd1, wd4, rdat1, rdat4;

  reg_mem2sram #(.MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(5), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .mem(b1.slave),
    .sram_ce(ce1), .sram_we(we1), .sram_addr(ad1), .sram_wdata(wd1),
    .sram_rdata(rdat1), .err_pulse(err1));

  reg_mem2sram #(.MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(5), .RD_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .mem(b4.slave),
    .sram_ce(ce4), .sram_we(we4), .sram_addr(ad4), .sram_wdata(wd4),
    .sram_rdata(rdat4), .err_pulse(err4));

  always #5 clk = ~clk;

  // Behavioural SRAMs: read data appears RD_LATENCY edges after sampled CE.
  logic [63:0] m1 [32];
  logic [63:0] m4 [32];
  logic [63:0] p1;
  logic [63:0] p4 [4];
  always @(posedge clk) begin
    if (ce1 && we1) m1[ad1] <= wd1;
    if (ce1 && !we1) p1 <= m1[ad1];
    if (ce4 && we4) m4[ad4] <= wd4;
    p4[0] <= (ce4 && !we4) ? m4[ad4] : 64'h0;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign rdat1 = p1;
  assign rdat4 = p4[3];

  // Per-cycle history, index [dut][cycle]; dut 0 = latency 1, dut 1 = latency 4.
  bit          ce_h  [2][32];
  bit          we_h  [2][32];
  bit          ack_h [2][32];
  bit          err_h [2][32];
  logic [4:0]  ad_h  [2][32];
  logic [63:0] wd_h  [2][32];
  logic [63:0] rd_h  [2][32];

  task automatic start_txn(input bit w, input bit r, input logic [4:0] a,
                           input logic [63:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d; req = 1'b1;
  endtask

  // Samples cycles 1..n at negedge. Request drops one cycle after dut1's ack
  // unless hold is set; soft_at pulses soft_rst (and drops req) in that cycle;
  // chg_at moves mem_addr/mem_wr_data to junk from that cycle on.
  task automatic observe(input int n, input int soft_at, input int chg_at,
                         input bit hold);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 32; c++) begin
        ce_h[d][c] = 0; we_h[d][c] = 0; ack_h[d][c] = 0; err_h[d][c] = 0;
      end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      ce_h[0][c] = ce1;  we_h[0][c] = we1;  ack_h[0][c] = b1.mem_ack_vld;
      err_h[0][c] = err1; ad_h[0][c] = ad1; wd_h[0][c] = wd1;
      rd_h[0][c] = b1.mem_rd_data;
      ce_h[1][c] = ce4;  we_h[1][c] = we4;  ack_h[1][c] = b4.mem_ack_vld;
      err_h[1][c] = err4; ad_h[1][c] = ad4; wd_h[1][c] = wd4;
      rd_h[1][c] = b4.mem_rd_data;
      soft_rst = (c == soft_at - 1);
      if (c == soft_at - 1) req = 1'b0;
      if (c == chg_at - 1) begin addr = 5'h1F; wdata = 64'h0; end
      if (!hold && c >= 2 && ack_h[0][c-1]) req = 1'b0;
    end
    soft_rst = 1'b0;
  endtask

  function automatic int first_ack(input int d);
    for (int c = 1; c < 32; c++) if (ack_h[d][c]) return c;
    return 0;
  endfunction

  function automatic int count_ce(input int d);
    int k = 0;
    for (int c = 1; c < 32; c++) if (ce_h[d][c]) k++;
    return k;
  endfunction

  function automatic int count_ack(input int d);
    int k = 0;
    for (int c = 1; c < 32; c++) if (ack_h[d][c]) k++;
    return k;
  endfunction

  task automatic test_reset();
    total++; if ({ce1, we1, err1, b1.mem_ack_vld} !== 4'b0) begin bad++;
      $display("FAIL reset_ctl1: got %b want 0000", {ce1, we1, err1, b1.mem_ack_vld}); end
    total++; if ({ad1, wd1, b1.mem_rd_data} !== '0) begin bad++;
      $display("FAIL reset_data1: addr=%h wdata=%h rd=%h want 0", ad1, wd1, b1.mem_rd_data); end
    total++; if ({ce4, we4, err4, b4.mem_ack_vld, ad4, wd4, b4.mem_rd_data} !== '0) begin bad++;
      $display("FAIL reset_all4: outputs of latency-4 instance not all 0"); end
  endtask

  task automatic test_write();
    start_txn(1, 0, 5'h0A, 64'hDEADBEEF_CAFEF00D);
    observe(6, -1, -1, 0);
    total++; if ({ce_h[0][1], we_h[0][1]} !== 2'b11) begin bad++;
      $display("FAIL wr_ce_we: got %b want 11", {ce_h[0][1], we_h[0][1]}); end
    total++; if (ad_h[0][1] !== 5'h0A || wd_h[0][1] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL wr_addr_data: got %h/%h want 0a/deadbeefcafef00d", ad_h[0][1], wd_h[0][1]); end
    total++; if (first_ack(0) != 2 || first_ack(1) != 2) begin bad++;
      $display("FAIL wr_ack_cycle: got %0d/%0d want 2/2", first_ack(0), first_ack(1)); end
    total++; if (count_ce(0) != 1 || count_ack(0) != 1) begin bad++;
      $display("FAIL wr_single: ce=%0d ack=%0d want 1/1", count_ce(0), count_ack(0)); end
    total++; if (err_h[0][1] || err_h[0][2] || err_h[0][3]) begin bad++;
      $display("FAIL wr_err: got err pulse want none"); end
  endtask

  task automatic test_read();
    start_txn(0, 1, 5'h0A, 64'h0);
    observe(10, -1, -1, 0);
    total++; if ({ce_h[0][1], we_h[0][1]} !== 2'b10 || ad_h[0][1] !== 5'h0A) begin bad++;
      $display("FAIL rd_issue: ce/we=%b addr=%h want 10/0a", {ce_h[0][1], we_h[0][1]}, ad_h[0][1]); end
    total++; if (first_ack(0) != 3 || count_ack(0) != 1) begin bad++;
      $display("FAIL rd_ack_l1: cycle=%0d count=%0d want 3/1", first_ack(0), count_ack(0)); end
    total++; if (rd_h[0][3] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL rd_data_l1: got %h want deadbeefcafef00d", rd_h[0][3]); end
    total++; if (first_ack(1) != 6 || count_ack(1) != 1) begin bad++;
      $display("FAIL rd_ack_l4: cycle=%0d count=%0d want 6/1", first_ack(1), count_ack(1)); end
    total++; if (rd_h[1][6] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL rd_data_l4: got %h want deadbeefcafef00d", rd_h[1][6]); end
    total++; if (rd_h[0][8] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL rd_data_held: got %h want deadbeefcafef00d", rd_h[0][8]); end
  endtask

  task automatic test_error();
    for (int k = 0; k < 2; k++) begin
      start_txn(k == 0, k == 0, 5'h0A, 64'h1234);
      observe(5, -1, -1, 0);
      total++; if (count_ce(0) != 0 || count_ce(1) != 0) begin bad++;
        $display("FAIL err_no_ce[%0d]: ce count %0d/%0d want 0", k, count_ce(0), count_ce(1)); end
      total++; if (first_ack(0) != 1 || !err_h[0][1] || err_h[0][2]) begin bad++;
        $display("FAIL err_ack[%0d]: ack cycle=%0d err1=%b err2=%b want 1/1/0",
                 k, first_ack(0), err_h[0][1], err_h[0][2]); end
      total++; if (rd_h[0][1] !== 64'h0 || rd_h[1][1] !== 64'h0) begin bad++;
        $display("FAIL err_rd_zero[%0d]: got %h/%h want 0", k, rd_h[0][1], rd_h[1][1]); end
      // Put non-zero read data back so the next error case can show the clear.
      if (k == 0) begin start_txn(0, 1, 5'h0A, 64'h0); observe(10, -1, -1, 0); end
    end
  endtask

  task automatic test_addr_change();
    start_txn(1, 0, 5'h1F, 64'hA5A5A5A5_5A5A5A5A);
    observe(5, -1, -1, 0);
    start_txn(0, 1, 5'h0A, 64'h0);
    observe(10, -1, 2, 0);
    total++; if (ad_h[0][1] !== 5'h0A || ad_h[1][1] !== 5'h0A) begin bad++;
      $display("FAIL chg_addr: got %h/%h want 0a", ad_h[0][1], ad_h[1][1]); end
    total++; if (rd_h[0][3] !== 64'hDEADBEEF_CAFEF00D || rd_h[1][6] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL chg_data: got %h/%h want deadbeefcafef00d", rd_h[0][3], rd_h[1][6]); end
  endtask

  task automatic test_soft_rst();
    start_txn(0, 1, 5'h0A, 64'h0);
    observe(10, 2, -1, 0);
    total++; if (count_ack(0) != 0 || count_ack(1) != 0) begin bad++;
      $display("FAIL srst_no_ack: ack count %0d/%0d want 0", count_ack(0), count_ack(1)); end
    total++; if ({ce_h[0][3], err_h[0][3], ad_h[0][3], rd_h[0][3]} !== '0 ||
                 {ce_h[1][3], err_h[1][3], ad_h[1][3], rd_h[1][3]} !== '0) begin bad++;
      $display("FAIL srst_zero: rd=%h/%h addr=%h/%h want 0", rd_h[0][3], rd_h[1][3], ad_h[0][3], ad_h[1][3]); end
    start_txn(0, 1, 5'h0A, 64'h0);
    observe(10, -1, -1, 0);
    total++; if (first_ack(0) != 3 || rd_h[0][3] !== 64'hDEADBEEF_CAFEF00D) begin bad++;
      $display("FAIL srst_recover: ack=%0d data=%h want 3/deadbeefcafef00d", first_ack(0), rd_h[0][3]); end
  endtask

  task automatic test_back_to_back();
    logic [16:1] ce_got, ce_exp, ack_got, ack_exp;
    start_txn(1, 0, 5'h03, 64'h0123_4567_89AB_CDEF);
    observe(16, -1, -1, 1);
    @(negedge clk); req = 1'b0;
    repeat (6) @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      ce_got[c] = ce_h[0][c];  ce_exp[c]  = (c % 4 == 1);
      ack_got[c] = ack_h[0][c]; ack_exp[c] = (c % 4 == 2);
    end
    total++; if (ce_got !== ce_exp) begin bad++;
      $display("FAIL b2b_ce: got %b want %b", ce_got, ce_exp); end
    total++; if (ack_got !== ack_exp) begin bad++;
      $display("FAIL b2b_ack: got %b want %b", ack_got, ack_exp); end
  endtask

  initial begin
    rst_n = 1'b0; soft_rst = 1'b0; req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_write();
    test_read();
    test_error();
    test_addr_change();
    test_soft_rst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
